// File: rtl/round_ctrl_pkg.sv
// round_ctrl_pkg: shared definitions for the round controller and the LED mux.
//   - state_t and St* : FSM state encodings (unlisted encodings are illegal)
//   - led_ctrl_t / Led*: led_control select codes consumed by the LED mux
//   - max3()           : helper for sizing the shared tick counter
package round_ctrl_pkg;

   typedef logic [3:0] state_t;

   localparam state_t StReset     = 4'd0;
   localparam state_t StWait      = 4'd1;
   localparam state_t StDark      = 4'd2;
   localparam state_t StPlay      = 4'd3;
   localparam state_t StGloat     = 4'd4;
   localparam state_t StFake      = 4'd5;
   localparam state_t StSpeed     = 4'd6;
   localparam state_t StSpeedDisp = 4'd7;
   localparam state_t StVictory   = 4'd8;

   typedef logic [2:0] led_ctrl_t;

   localparam led_ctrl_t LedDark    = 3'b000;
   localparam led_ctrl_t LedReset   = 3'b001;
   localparam led_ctrl_t LedAllOn   = 3'b010;
   localparam led_ctrl_t LedScore   = 3'b011;
   localparam led_ctrl_t LedFake    = 3'b100;
   localparam led_ctrl_t LedSpeed   = 3'b110;
   localparam led_ctrl_t LedVictory = 3'b111;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/round_ctrl_if.sv
// round_ctrl_if: game-side signals of the round controller.
//   Inputs to the controller (suffix _i): slowen, rnd/rnd_fake/rnd_speed round selectors,
//   fake/speed enables, winrnd, winspeed, speed_exit, victory.
//   Outputs from the controller (suffix _o): leds_on, clear, led_control, fake,
//   speed_round, round_cnt.
//   modport slave  : the controller itself.
//   modport master : whatever drives the game inputs (game logic or a testbench).
interface round_ctrl_if #(
   parameter int unsigned RCNT_W = 4
) ();

   logic              slowen_i;
   logic              rnd_i;
   logic              rnd_fake_i;
   logic              rnd_speed_i;
   logic              fake_en_i;
   logic              speed_en_i;
   logic              winrnd_i;
   logic              winspeed_i;
   logic              speed_exit_i;
   logic              victory_i;

   logic              leds_on_o;
   logic              clear_o;
   logic [2:0]        led_control_o;
   logic              fake_o;
   logic              speed_round_o;
   logic [RCNT_W-1:0] round_cnt_o;

   modport slave (
      input  slowen_i, rnd_i, rnd_fake_i, rnd_speed_i, fake_en_i, speed_en_i,
             winrnd_i, winspeed_i, speed_exit_i, victory_i,
      output leds_on_o, clear_o, led_control_o, fake_o, speed_round_o, round_cnt_o
   );

   modport master (
      output slowen_i, rnd_i, rnd_fake_i, rnd_speed_i, fake_en_i, speed_en_i,
             winrnd_i, winspeed_i, speed_exit_i, victory_i,
      input  leds_on_o, clear_o, led_control_o, fake_o, speed_round_o, round_cnt_o
   );

endinterface

// File: rtl/round_ctrl_tick_cnt.sv
// tick_cnt: shared slow-tick counter for the round controller.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   clr_i    : synchronous clear (wins over en_i)
//   en_i     : count enable (one increment per cycle)
//   tc_val_i : terminal-count value to compare against
//   tc_o     : high while the count equals tc_val_i
module tick_cnt #(
   parameter int unsigned Width = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [Width-1:0] tc_val_i,
   output logic             tc_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/round_ctrl.sv
// round_ctrl: reaction-game round sequencer.
//   clk : system clock, all state on the rising edge
//   rst : asynchronous active-high reset
//   bus : round_ctrl_if.slave -- game inputs (slow tick, random selectors, enables,
//         win/exit/victory events) and Moore outputs (LED control, clear, fake,
//         speed_round, saturating completed-round count).
// Timed states (WAIT, GLOAT, FAKE) share one tick counter that is cleared on every
// state change; the slow tick is only ever used as an enable.
module round_ctrl
   import round_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_TICKS  = 2,
   parameter int unsigned GLOAT_TICKS = 2,
   parameter int unsigned FAKE_TICKS  = 3,
   parameter int unsigned MAX_ROUNDS  = 0,
   parameter int unsigned RCNT_W      = 4
) (
   input logic          clk,
   input logic          rst,
   round_ctrl_if.slave  bus
);

   localparam int unsigned MaxTicks = max3(WAIT_TICKS, GLOAT_TICKS, FAKE_TICKS);
   localparam int unsigned TcntW    = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;

   localparam logic [TcntW-1:0] WaitTc  = TcntW'(WAIT_TICKS - 1);
   localparam logic [TcntW-1:0] GloatTc = TcntW'(GLOAT_TICKS - 1);
   localparam logic [TcntW-1:0] FakeTc  = TcntW'(FAKE_TICKS - 1);

   localparam bit                RoundsLimited = (MAX_ROUNDS != 0);
   localparam logic [RCNT_W-1:0] MaxRounds     = RCNT_W'(MAX_ROUNDS);

   state_t            state_q, state_d;
   logic [RCNT_W-1:0] round_cnt_q, round_cnt_d;

   logic              cnt_clr;
   logic              cnt_en;
   logic [TcntW-1:0]  tc_val;
   logic              tc_hit;

   // Counter control depends on registered state only, keeping tc_hit free of
   // any path back through state_d.
   always_comb begin
      tc_val = '0;
      cnt_en = 1'b0;
      case (state_q)
         StWait: begin
            tc_val = WaitTc;
            cnt_en = bus.slowen_i;
         end
         StGloat: begin
            tc_val = GloatTc;
            cnt_en = bus.slowen_i;
         end
         StFake: begin
            tc_val = FakeTc;
            cnt_en = bus.slowen_i;
         end
         default: begin
            tc_val = '0;
            cnt_en = 1'b0;
         end
      endcase
   end

   tick_cnt #(
      .Width (TcntW)
   ) u_tick_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (cnt_clr),
      .en_i     (cnt_en),
      .tc_val_i (tc_val),
      .tc_o     (tc_hit)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         StReset: state_d = StWait;
         StWait: begin
            if (bus.slowen_i && tc_hit) state_d = StDark;
         end
         StDark: begin
            if (bus.victory_i) begin
               state_d = StVictory;
            end else if (bus.slowen_i && bus.rnd_i) begin
               state_d = StPlay;
            end else if (bus.slowen_i && bus.rnd_fake_i && bus.fake_en_i) begin
               state_d = StFake;
            end else if (bus.slowen_i && bus.rnd_speed_i && bus.speed_en_i) begin
               state_d = StSpeed;
            end else if (bus.winrnd_i) begin
               // Button pressed while dark: false start, round still counts.
               state_d = StGloat;
            end
         end
         StPlay: begin
            if (bus.winrnd_i) state_d = StGloat;
         end
         StFake: begin
            if (bus.winrnd_i) begin
               state_d = StGloat;
            end else if (bus.slowen_i && tc_hit) begin
               state_d = StDark;
            end
         end
         StSpeed: begin
            if (bus.winspeed_i) state_d = StSpeedDisp;
         end
         StSpeedDisp: begin
            if (bus.speed_exit_i) state_d = StGloat;
         end
         StGloat: begin
            if (bus.slowen_i && tc_hit) begin
               if (RoundsLimited && (round_cnt_q >= MaxRounds)) begin
                  state_d = StVictory;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StVictory: state_d = StVictory;
         default:   state_d = StReset;
      endcase
   end

   assign cnt_clr = (state_d != state_q);

   always_comb begin
      round_cnt_d = round_cnt_q;
      if ((state_d == StGloat) && (state_q != StGloat) && (round_cnt_q != '1)) begin
         round_cnt_d = round_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StReset;
         round_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         round_cnt_q <= round_cnt_d;
      end
   end

   // Moore output decode; illegal encodings show the RESET row for their single cycle.
   always_comb begin
      bus.leds_on_o     = 1'b1;
      bus.clear_o       = 1'b1;
      bus.led_control_o = LedReset;
      bus.fake_o        = 1'b0;
      bus.speed_round_o = 1'b0;
      case (state_q)
         StReset: bus.led_control_o = LedReset;
         StWait:  bus.led_control_o = LedAllOn;
         StDark: begin
            bus.leds_on_o     = 1'b0;
            bus.clear_o       = 1'b0;
            bus.led_control_o = LedDark;
         end
         StPlay: begin
            bus.clear_o       = 1'b0;
            bus.led_control_o = LedScore;
         end
         StGloat: bus.led_control_o = LedScore;
         StFake: begin
            bus.clear_o       = 1'b0;
            bus.led_control_o = LedFake;
            bus.fake_o        = 1'b1;
         end
         StSpeed: begin
            bus.led_control_o = LedSpeed;
            bus.speed_round_o = 1'b1;
         end
         StSpeedDisp: bus.led_control_o = LedSpeed;
         StVictory:   bus.led_control_o = LedVictory;
         default:     bus.led_control_o = LedReset;
      endcase
   end

   assign bus.round_cnt_o = round_cnt_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl with WAIT=2, GLOAT=2, FAKE=3, MAX_ROUNDS=2, RCNT_W=4.
module tb_round_ctrl;

   // Input word bits: {rst, slowen, rnd, rnd_fake, rnd_speed, fake_en, speed_en,
   //                   winrnd, winspeed, speed_exit, victory}
   localparam logic [10:0] INone   = 11'h000;
   localparam logic [10:0] IRst    = 11'h400;
   localparam logic [10:0] ISlow   = 11'h200;
   localparam logic [10:0] IRand   = 11'h100;
   localparam logic [10:0] IRFake  = 11'h080;
   localparam logic [10:0] IRSpeed = 11'h040;
   localparam logic [10:0] IFakeEn = 11'h020;
   localparam logic [10:0] ISpdEn  = 11'h010;
   localparam logic [10:0] IWin    = 11'h008;
   localparam logic [10:0] IWinSpd = 11'h004;
   localparam logic [10:0] ISExit  = 11'h002;
   localparam logic [10:0] IVict   = 11'h001;

   // Expected outputs {leds_on, clear, led_control[2:0], fake, speed_round}
   localparam logic [6:0] OReset = 7'b1_1_001_0_0;
   localparam logic [6:0] OWait  = 7'b1_1_010_0_0;
   localparam logic [6:0] ODark  = 7'b0_0_000_0_0;
   localparam logic [6:0] OPlay  = 7'b1_0_011_0_0;
   localparam logic [6:0] OGloat = 7'b1_1_011_0_0;
   localparam logic [6:0] OFake  = 7'b1_0_100_1_0;
   localparam logic [6:0] OSpeed = 7'b1_1_110_0_1;
   localparam logic [6:0] OSDisp = 7'b1_1_110_0_0;
   localparam logic [6:0] OVict  = 7'b1_1_111_0_0;

   typedef struct {
      logic [10:0] in;
      logic [6:0]  eo;
      logic [3:0]  erc;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   vec_t vecs[$];

   round_ctrl_if #(.RCNT_W(4)) ifc ();

   round_ctrl #(
      .WAIT_TICKS  (2),
      .GLOAT_TICKS (2),
      .FAKE_TICKS  (3),
      .MAX_ROUNDS  (2),
      .RCNT_W      (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [10:0] in);
      rst              = in[10];
      ifc.slowen_i     = in[9];
      ifc.rnd_i        = in[8];
      ifc.rnd_fake_i   = in[7];
      ifc.rnd_speed_i  = in[6];
      ifc.fake_en_i    = in[5];
      ifc.speed_en_i   = in[4];
      ifc.winrnd_i     = in[3];
      ifc.winspeed_i   = in[2];
      ifc.speed_exit_i = in[1];
      ifc.victory_i    = in[0];
   endtask

   task automatic check(input string name, input logic [6:0] eo, input logic [3:0] erc);
      logic [6:0] ao;
      ao = {ifc.leds_on_o, ifc.clear_o, ifc.led_control_o, ifc.fake_o, ifc.speed_round_o};
      checks++;
      if (ao !== eo || ifc.round_cnt_o !== erc) begin
         failures++;
         $display("FAIL %s: got out=%b rc=%0d, want out=%b rc=%0d",
                  name, ao, ifc.round_cnt_o, eo, erc);
      end
   endtask

   // Drive inputs 1 time unit after an edge, clock once, sample 1 after the edge.
   task automatic step(input string name, input logic [10:0] in,
                       input logic [6:0] eo, input logic [3:0] erc);
      drive(in);
      @(posedge clk);
      #1;
      check(name, eo, erc);
   endtask

   function automatic void add(input logic [10:0] in, input logic [6:0] eo,
                               input logic [3:0] erc);
      vec_t v;
      v.in  = in;
      v.eo  = eo;
      v.erc = erc;
      vecs.push_back(v);
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      drive(IRst);

      // Reset release, WAIT timing, PLAY round
      add(IRst,                 OReset, 4'd0);  // 0
      add(INone,                OWait,  4'd0);
      add(INone,                OWait,  4'd0);
      add(ISlow,                OWait,  4'd0);
      add(ISlow,                ODark,  4'd0);
      add(INone,                ODark,  4'd0);  // 5
      add(ISlow,                ODark,  4'd0);
      add(ISlow | IRSpeed,      ODark,  4'd0);  // speed disabled
      add(ISlow | IRand,        OPlay,  4'd0);
      add(ISlow,                OPlay,  4'd0);
      add(IWin,                 OGloat, 4'd1);  // 10
      add(ISlow,                OGloat, 4'd1);
      add(ISlow,                OWait,  4'd1);
      add(ISlow,                OWait,  4'd1);
      add(ISlow,                ODark,  4'd1);
      // Fake round times out after three ticks
      add(ISlow | IRFake | IFakeEn, OFake, 4'd1); // 15
      add(ISlow,                OFake,  4'd1);
      add(ISlow,                OFake,  4'd1);
      add(ISlow,                ODark,  4'd1);
      // Speed round
      add(ISlow | IRSpeed | ISpdEn, OSpeed, 4'd1);
      add(ISlow,                OSpeed, 4'd1);  // 20
      add(IWinSpd,              OSDisp, 4'd1);
      add(INone,                OSDisp, 4'd1);
      add(ISExit,               OGloat, 4'd2);
      add(ISlow,                OGloat, 4'd2);
      add(ISlow,                OVict,  4'd2);  // 25
      add(11'h3FF,              OVict,  4'd2);  // everything but rst ignored
      add(ISlow | IWin | IVict, OVict,  4'd2);
      add(IRst,                 OReset, 4'd0);
      add(INone,                OWait,  4'd0);
      add(ISlow,                OWait,  4'd0);  // 30
      add(ISlow,                ODark,  4'd0);
      // Tick-based choice beats winrnd; winrnd on the third fake tick wins
      add(ISlow | IRFake | IFakeEn | IWin, OFake, 4'd0);
      add(ISlow,                OFake,  4'd0);
      add(ISlow,                OFake,  4'd0);
      add(ISlow | IWin,         OGloat, 4'd1);  // 35
      add(ISlow,                OGloat, 4'd1);
      add(ISlow,                OWait,  4'd1);
      add(ISlow,                OWait,  4'd1);
      add(ISlow,                ODark,  4'd1);
      add(IWin,                 OGloat, 4'd2);  // 40: false start
      add(ISlow,                OGloat, 4'd2);
      add(ISlow,                OVict,  4'd2);
      add(IRst,                 OReset, 4'd0);
      add(INone,                OWait,  4'd0);
      add(ISlow,                OWait,  4'd0);  // 45
      add(ISlow,                ODark,  4'd0);
      add(ISlow | IRand | IRFake | IFakeEn | IRSpeed | ISpdEn, OPlay, 4'd0);
      add(IRst,                 OReset, 4'd0);
      add(INone,                OWait,  4'd0);
      add(ISlow,                OWait,  4'd0);  // 50
      add(ISlow,                ODark,  4'd0);
      add(IVict,                OVict,  4'd0);  // external victory from DARK
      add(IRst,                 OReset, 4'd0);
      add(INone,                OWait,  4'd0);
      add(ISlow,                OWait,  4'd0);  // 55
      add(ISlow,                ODark,  4'd0);
      add(ISlow | IRFake,       ODark,  4'd0);  // fake disabled

      #2;
      foreach (vecs[i]) begin
         step($sformatf("vec%0d", i), vecs[i].in, vecs[i].eo, vecs[i].erc);
      end

      // Asynchronous reset mid-FAKE: immediate RESET, counter cleared
      step("fake_enter", ISlow | IRFake | IFakeEn, OFake, 4'd0);
      step("fake_tick1", ISlow, OFake, 4'd0);
      rst = 1'b1;
      #1;
      check("rst_mid_fake", OReset, 4'd0);
      @(posedge clk);
      #1;
      step("fake_rst_wait0", INone, OWait, 4'd0);
      step("fake_rst_wait1", ISlow, OWait, 4'd0);
      step("fake_rst_dark", ISlow, ODark, 4'd0);

      // Asynchronous reset mid-GLOAT: round count cleared too
      step("gl_play", ISlow | IRand, OPlay, 4'd0);
      step("gl_enter", IWin, OGloat, 4'd1);
      step("gl_tick1", ISlow, OGloat, 4'd1);
      drive(IRst);
      #1;
      check("rst_mid_gloat", OReset, 4'd0);
      @(posedge clk);
      #1;
      step("gl_rst_wait0", INone, OWait, 4'd0);
      step("gl_rst_wait1", ISlow, OWait, 4'd0);
      step("gl_rst_dark", ISlow, ODark, 4'd0);
      step("gl2_enter", IWin, OGloat, 4'd1);
      step("gl2_tick1", ISlow, OGloat, 4'd1);
      step("gl2_wait", ISlow, OWait, 4'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
